// File: rtl/vecgate_pkg.sv
// Shared widths, entry bit positions and the result-set consistency check
// for the vectorgates result buffer.
package vecgate_pkg;

  localparam int VG_W    = 3;
  localparam int NOT_W   = 6;
  localparam int ENTRY_W = 11;

  localparam int ERR_BIT = 10;
  localparam int NOT_LSB = 4;
  localparam int LOG_BIT = 3;
  localparam int OR_LSB  = 0;

  // Field order matches the bit positions above: {err, not, or_logical, or_bitwise}.
  typedef struct packed {
    logic             err;
    logic [NOT_W-1:0] inv;
    logic             or_logical;
    logic [VG_W-1:0]  or_bitwise;
  } vecgate_entry_t;

  // Recovers a and b from the inverted operands and flags any disagreement
  // between them and the reported OR results.
  function automatic logic vecgate_check_err(
    input logic [VG_W-1:0]  or_bitwise,
    input logic             or_logical,
    input logic [NOT_W-1:0] inv
  );
    logic [VG_W-1:0] exp_or;
    exp_or = ~inv[NOT_W-1:VG_W] | ~inv[VG_W-1:0];
    return (or_bitwise != exp_or) | (or_logical != (|or_bitwise));
  endfunction

endpackage

// File: rtl/vecgate_sync_fifo.sv
// Single-clock show-ahead FIFO: the head entry is presented combinationally
// and only advances on pop. Push is refused when full and pop when empty.
module vecgate_sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_q == LEVEL_FULL);
  assign empty   = (level_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign level   = level_q;

  // Zero while empty so the output is defined after reset without clearing mem.
  assign head = empty ? '0 : mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (do_pop && !do_push) level_q <= level_q - 1'b1;
    end
  end

  // NOTE: the storage array has no reset; the pointers and level define which
  // words are meaningful, so a reset here would only cost a reset tree on RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vecgate_result_buffer.sv
// Captures vectorgates result sets over valid/ready, tags each with a
// consistency error bit, queues them and keeps saturating statistics.
module vecgate_result_buffer
  import vecgate_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [VG_W-1:0]          in_or_bitwise,
  input  logic                     in_or_logical,
  input  logic [NOT_W-1:0]         in_not,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ENTRY_W-1:0]       out_data,
  output logic [$clog2(DEPTH):0]   level,
  input  logic                     clr_stats,
  output logic [CNT_W-1:0]         accept_cnt,
  output logic [CNT_W-1:0]         true_cnt,
  output logic [CNT_W-1:0]         err_cnt,
  output logic                     err_sticky
);

  vecgate_entry_t entry;
  logic           accept;
  logic           pop;
  logic           fifo_full;
  logic           fifo_empty;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    entry            = '0;
    entry.err        = vecgate_check_err(in_or_bitwise, in_or_logical, in_not);
    entry.inv        = in_not;
    entry.or_logical = in_or_logical;
    entry.or_bitwise = in_or_bitwise;
  end

  // in_ready depends only on registered occupancy: a full buffer refuses
  // input even when the consumer pops in the same cycle.
  assign in_ready  = ~fifo_full;
  assign out_valid = ~fifo_empty;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  vecgate_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (entry),
    .pop       (pop),
    .head      (out_data),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Clear takes priority over counting; a coincident accept is still queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accept_cnt <= '0;
      true_cnt   <= '0;
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (clr_stats) begin
      accept_cnt <= '0;
      true_cnt   <= '0;
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (accept) begin
      if (accept_cnt != '1)                   accept_cnt <= accept_cnt + 1'b1;
      if (in_or_logical && (true_cnt != '1))  true_cnt   <= true_cnt + 1'b1;
      if (entry.err && (err_cnt != '1))       err_cnt    <= err_cnt + 1'b1;
      if (entry.err)                          err_sticky <= 1'b1;
    end
  end

endmodule
